// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for the screen path. A clock-enable divider
//   produces one pixel tick every CLK_DIV system clocks. Pixel/line/frame
//   counters advance on that tick. Sync and active-video flags can be delayed
//   by PIPE ticks so they stay aligned with a pipelined pixel generator.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   en           run enable; low clears all state on the next edge
//   pix_en       one-clk pixel tick
//   hsync/vsync  sync outputs, delayed PIPE ticks, polarity H_POL/V_POL
//   valid        active video, delayed PIPE ticks
//   h_cnt/v_cnt  coordinates inside the active area (0 outside), undelayed
//   line_start   tick at pixel 0 of every line
//   frame_start  tick at pixel 0 of line 0
//   frame_cnt    completed frames, wraps at 16 bits
module vga_timing_gen #(
    parameter int unsigned HD      = 640,
    parameter int unsigned HF      = 16,
    parameter int unsigned HS      = 96,
    parameter int unsigned HB      = 48,
    parameter int unsigned VD      = 480,
    parameter int unsigned VF      = 10,
    parameter int unsigned VS      = 2,
    parameter int unsigned VB      = 33,
    parameter int unsigned H_POL   = 0,
    parameter int unsigned V_POL   = 0,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned PIPE    = 0,
    parameter int unsigned CW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          valid,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned HT  = HD + HF + HS + HB;
    localparam int unsigned VT  = VD + VF + VS + VB;
    localparam int unsigned PXW = (HT > 1) ? $clog2(HT) : 1;
    localparam int unsigned LNW = (VT > 1) ? $clog2(VT) : 1;
    localparam int unsigned DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SW  = (PIPE > 0) ? PIPE : 1;

    localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);
    localparam logic [PXW-1:0] PX_LAST  = PXW'(HT - 1);
    localparam logic [LNW-1:0] LN_LAST  = LNW'(VT - 1);
    localparam logic [PXW-1:0] PX_ACT   = PXW'(HD);
    localparam logic [LNW-1:0] LN_ACT   = LNW'(VD);
    localparam logic [PXW-1:0] HS_BEG   = PXW'(HD + HF);
    localparam logic [PXW-1:0] HS_END   = PXW'(HD + HF + HS - 1);
    localparam logic [LNW-1:0] VS_BEG   = LNW'(VD + VF);
    localparam logic [LNW-1:0] VS_END   = LNW'(VD + VF + VS - 1);

    logic [DVW-1:0] div_q,       div_d;
    logic [PXW-1:0] pixel_q,     pixel_d;
    logic [LNW-1:0] line_q,      line_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [SW-1:0]  hs_q,        hs_d;
    logic [SW-1:0]  vs_q,        vs_d;
    logic [SW-1:0]  va_q,        va_d;

    logic tick;
    logic live;
    logic hs_raw, vs_raw, va_raw;
    logic hs_o, vs_o, va_o;

    assign tick = en & (div_q == DIV_LAST);

    // Outputs are forced to their idle values combinationally whenever the
    // block is held (reset or en low), so they clear without waiting a clock.
    assign live = en & rst;

    assign hs_raw = (pixel_q >= HS_BEG) && (pixel_q <= HS_END);
    assign vs_raw = (line_q >= VS_BEG) && (line_q <= VS_END);
    assign va_raw = (pixel_q < PX_ACT) && (line_q < LN_ACT);

    always_comb begin
        div_d       = div_q;
        pixel_d     = pixel_q;
        line_d      = line_q;
        frame_cnt_d = frame_cnt_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        va_d        = va_q;
        if (!en) begin
            div_d       = '0;
            pixel_d     = '0;
            line_d      = '0;
            frame_cnt_d = '0;
            hs_d        = '0;
            vs_d        = '0;
            va_d        = '0;
        end else if (tick) begin
            div_d = '0;
            // Delay line: stage 0 takes the current decode, last stage drives out.
            hs_d  = (hs_q << 1) | SW'(hs_raw);
            vs_d  = (vs_q << 1) | SW'(vs_raw);
            va_d  = (va_q << 1) | SW'(va_raw);
            if (pixel_q == PX_LAST) begin
                pixel_d = '0;
                if (line_q == LN_LAST) begin
                    line_d      = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    line_d = line_q + LNW'(1);
                end
            end else begin
                pixel_d = pixel_q + PXW'(1);
            end
        end else begin
            div_d = div_q + DVW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q       <= '0;
            pixel_q     <= '0;
            line_q      <= '0;
            frame_cnt_q <= '0;
            hs_q        <= '0;
            vs_q        <= '0;
            va_q        <= '0;
        end else begin
            div_q       <= div_d;
            pixel_q     <= pixel_d;
            line_q      <= line_d;
            frame_cnt_q <= frame_cnt_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            va_q        <= va_d;
        end
    end

    assign hs_o = live & ((PIPE == 0) ? hs_raw : hs_q[SW-1]);
    assign vs_o = live & ((PIPE == 0) ? vs_raw : vs_q[SW-1]);
    assign va_o = live & ((PIPE == 0) ? va_raw : va_q[SW-1]);

    assign pix_en      = live & (div_q == DIV_LAST);
    assign hsync       = (H_POL != 0) ? hs_o : ~hs_o;
    assign vsync       = (V_POL != 0) ? vs_o : ~vs_o;
    assign valid       = va_o;
    assign h_cnt       = (live && (pixel_q < PX_ACT)) ? CW'(pixel_q) : '0;
    assign v_cnt       = (live && (line_q < LN_ACT)) ? CW'(line_q) : '0;
    assign line_start  = pix_en & (pixel_q == '0);
    assign frame_start = line_start & (line_q == '0);
    assign frame_cnt   = live ? frame_cnt_q : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pix_en;
        logic        hsync;
        logic        vsync;
        logic        valid;
        logic        ls;
        logic        fs;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [15:0] fc;
    } outs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n       = 0;   // clocks elapsed since the generator started
    int unsigned foff    = 0;   // frame offset for the forced-wrap instance

    // d: default horizontal timing, short vertical, CLK_DIV=4
    logic d_pe, d_hs, d_vs, d_va, d_ls, d_fs; logic [9:0] d_h, d_v; logic [15:0] d_fc;
    // s: small geometry, CLK_DIV=1
    logic s_pe, s_hs, s_vs, s_va, s_ls, s_fs; logic [9:0] s_h, s_v; logic [15:0] s_fc;
    // p: small geometry, PIPE=2
    logic p_pe, p_hs, p_vs, p_va, p_ls, p_fs; logic [9:0] p_h, p_v; logic [15:0] p_fc;
    // q: small geometry, active-high syncs, CLK_DIV=3, PIPE=1
    logic q_pe, q_hs, q_vs, q_va, q_ls, q_fs; logic [9:0] q_h, q_v; logic [15:0] q_fc;

    vga_timing_gen #(.HD(640), .HF(16), .HS(96), .HB(48), .VD(6), .VF(2), .VS(2), .VB(2),
                     .H_POL(0), .V_POL(0), .CLK_DIV(4), .PIPE(0), .CW(10)) dut_d (
        .clk(clk), .rst(rst), .en(en), .pix_en(d_pe), .hsync(d_hs), .vsync(d_vs),
        .valid(d_va), .h_cnt(d_h), .v_cnt(d_v), .line_start(d_ls),
        .frame_start(d_fs), .frame_cnt(d_fc));

    vga_timing_gen #(.HD(4), .HF(1), .HS(2), .HB(1), .VD(3), .VF(1), .VS(1), .VB(1),
                     .H_POL(0), .V_POL(0), .CLK_DIV(1), .PIPE(0), .CW(10)) dut_s (
        .clk(clk), .rst(rst), .en(en), .pix_en(s_pe), .hsync(s_hs), .vsync(s_vs),
        .valid(s_va), .h_cnt(s_h), .v_cnt(s_v), .line_start(s_ls),
        .frame_start(s_fs), .frame_cnt(s_fc));

    vga_timing_gen #(.HD(4), .HF(1), .HS(2), .HB(1), .VD(3), .VF(1), .VS(1), .VB(1),
                     .H_POL(0), .V_POL(0), .CLK_DIV(1), .PIPE(2), .CW(10)) dut_p (
        .clk(clk), .rst(rst), .en(en), .pix_en(p_pe), .hsync(p_hs), .vsync(p_vs),
        .valid(p_va), .h_cnt(p_h), .v_cnt(p_v), .line_start(p_ls),
        .frame_start(p_fs), .frame_cnt(p_fc));

    vga_timing_gen #(.HD(4), .HF(1), .HS(2), .HB(1), .VD(3), .VF(1), .VS(1), .VB(1),
                     .H_POL(1), .V_POL(1), .CLK_DIV(3), .PIPE(1), .CW(10)) dut_q (
        .clk(clk), .rst(rst), .en(en), .pix_en(q_pe), .hsync(q_hs), .vsync(q_vs),
        .valid(q_va), .h_cnt(q_h), .v_cnt(q_v), .line_start(q_ls),
        .frame_start(q_fs), .frame_cnt(q_fc));

    // Reference: position derived from elapsed clocks by plain division.
    function automatic outs_t model(input int unsigned hd, hf, hs, hb, vd, vf, vs, vb,
                                    input int unsigned hpol, vpol, cd, pipe,
                                    input bit live, input int unsigned fo);
        outs_t o;
        int unsigned ht, vt, t, px, ln, td, pxd, lnd;
        bit hsa, vsa, va;
        o = '0;
        if (!live) begin
            o.hsync = (hpol == 0);
            o.vsync = (vpol == 0);
            return o;
        end
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        t  = n / cd;
        px = t % ht;
        ln = (t / ht) % vt;
        o.pix_en = ((n % cd) == cd - 1);
        o.h  = (px < hd) ? 10'(px) : 10'd0;
        o.v  = (ln < vd) ? 10'(ln) : 10'd0;
        o.fc = 16'((fo + t / (ht * vt)) % 65536);
        o.ls = o.pix_en && (px == 0);
        o.fs = o.ls && (ln == 0);
        hsa = 0; vsa = 0; va = 0;
        if (t >= pipe) begin
            td  = t - pipe;
            pxd = td % ht;
            lnd = (td / ht) % vt;
            hsa = (pxd >= hd + hf) && (pxd < hd + hf + hs);
            vsa = (lnd >= vd + vf) && (lnd < vd + vf + vs);
            va  = (pxd < hd) && (lnd < vd);
        end
        o.hsync = (hpol != 0) ? hsa : !hsa;
        o.vsync = (vpol != 0) ? vsa : !vsa;
        o.valid = va;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s at n=%0d: got %0h, expected %0h", tag, n, got, exp);
    endtask

    task automatic cmp(input string pfx, input outs_t g, input outs_t e);
        chk({pfx, ".pix_en"},      16'(g.pix_en), 16'(e.pix_en));
        chk({pfx, ".hsync"},       16'(g.hsync),  16'(e.hsync));
        chk({pfx, ".vsync"},       16'(g.vsync),  16'(e.vsync));
        chk({pfx, ".valid"},       16'(g.valid),  16'(e.valid));
        chk({pfx, ".line_start"},  16'(g.ls),     16'(e.ls));
        chk({pfx, ".frame_start"}, 16'(g.fs),     16'(e.fs));
        chk({pfx, ".h_cnt"},       16'(g.h),      16'(e.h));
        chk({pfx, ".v_cnt"},       16'(g.v),      16'(e.v));
        chk({pfx, ".frame_cnt"},   g.fc,          e.fc);
    endtask

    task automatic check_all();
        bit live;
        live = rst && en;
        cmp("d", '{pix_en:d_pe, hsync:d_hs, vsync:d_vs, valid:d_va, ls:d_ls, fs:d_fs, h:d_h, v:d_v, fc:d_fc},
            model(640, 16, 96, 48, 6, 2, 2, 2, 0, 0, 4, 0, live, 0));
        cmp("s", '{pix_en:s_pe, hsync:s_hs, vsync:s_vs, valid:s_va, ls:s_ls, fs:s_fs, h:s_h, v:s_v, fc:s_fc},
            model(4, 1, 2, 1, 3, 1, 1, 1, 0, 0, 1, 0, live, foff));
        cmp("p", '{pix_en:p_pe, hsync:p_hs, vsync:p_vs, valid:p_va, ls:p_ls, fs:p_fs, h:p_h, v:p_v, fc:p_fc},
            model(4, 1, 2, 1, 3, 1, 1, 1, 0, 0, 1, 2, live, 0));
        cmp("q", '{pix_en:q_pe, hsync:q_hs, vsync:q_vs, valid:q_va, ls:q_ls, fs:q_fs, h:q_h, v:q_v, fc:q_fc},
            model(4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 3, 1, live, 0));
    endtask

    // One clock: advance the model at the edge, change inputs mid-high
    // (asynchronously for rst), then check all instances on the falling edge.
    task automatic run_cycle(input bit new_rst, input bit new_en);
        @(posedge clk);
        if (rst && en) n++;
        else begin
            n    = 0;
            foff = 0;
        end
        #3;
        rst = new_rst;
        en  = new_en;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int unsigned s_va_clks, d_hs_ticks, d_vs_clks, len, kind, gap;
        bit found;
        s_va_clks = 0; d_hs_ticks = 0; d_vs_clks = 0;

        // Held in reset: idle levels everywhere.
        repeat (3) run_cycle(1'b0, 1'b1);
        chk("q.hsync_idle_in_reset", 16'(q_hs), 16'd0);
        chk("d.hsync_idle_in_reset", 16'(d_hs), 16'd1);

        // One uninterrupted frame of the longest instance.
        for (int unsigned i = 0; i < 38500; i++) begin
            run_cycle(1'b1, 1'b1);
            if (n < 48 && s_va) s_va_clks++;
            if (n < 3200 && d_pe && !d_hs) d_hs_ticks++;
            if (n < 38400 && !d_vs) d_vs_clks++;
            if (n < 4) chk("d.first_pix_en", 16'(d_pe), 16'(n == 3));
            if (n < 2) chk("p.valid_prefill", 16'(p_va), 16'd0);
            if (n == 2) chk("p.valid_rise", 16'(p_va), 16'd1);
            if (n == 144) chk("s.frame_cnt_at_144", s_fc, 16'd3);
        end
        chk("s.valid_clks_per_frame", 16'(s_va_clks), 16'd12);
        chk("d.hsync_ticks_line0", 16'(d_hs_ticks), 16'd96);
        chk("d.vsync_clks_frame0", 16'(d_vs_clks), 16'd6400);

        // Drop en at pixel (5,2) of the small geometry.
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            run_cycle(1'b1, 1'b1);
            if ((n % 8) == 5 && ((n / 8) % 6) == 2) found = 1;
        end
        chk("s.found_pixel_5_2", 16'(found), 16'd1);
        run_cycle(1'b1, 1'b0);
        chk("s.en_low_valid", 16'(s_va), 16'd0);
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b1);
        chk("s.restart_frame_start", 16'(s_fs), 16'd1);

        // Asynchronous reset mid-line.
        repeat (50) run_cycle(1'b1, 1'b1);
        run_cycle(1'b0, 1'b1);
        chk("d.rst_async_hsync", 16'(d_hs), 16'd1);
        run_cycle(1'b0, 1'b1);

        // Random run lengths and interruptions.
        for (int seg = 0; seg < 12; seg++) begin
            len  = $urandom_range(30, 400);
            kind = $urandom_range(0, 2);
            gap  = $urandom_range(1, 4);
            repeat (len) run_cycle(1'b1, 1'b1);
            repeat (gap) run_cycle(kind != 1, kind == 1);
        end

        // Frame counter wrap on the small instance.
        repeat (20) run_cycle(1'b1, 1'b1);
        foff = 65535 - (n / 48);
        force dut_s.frame_cnt_q = 16'hFFFF;
        #1;
        release dut_s.frame_cnt_q;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            run_cycle(1'b1, 1'b1);
            if (s_fs) found = 1;
        end
        chk("s.wrap_frame_start_seen", 16'(found), 16'd1);
        chk("s.frame_cnt_wrapped", s_fc, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
